// File: rtl/evo_xb_info_table.sv
// evo_xb_info_table: read-only info table behind indirect INDEX/DATA CSRs with post-reset checksum scan.
// Optional: EVO_XB_INFO_TABLE_AUTOINC_EN enables INDEX auto-increment on DATA reads.
module evo_xb_info_table #(
    parameter int                        CSR_AWIDTH  = 8,
    parameter int                        CSR_DWIDTH  = 32,
    parameter logic [CSR_AWIDTH-1:0]     BASE_ADDR   = '0,
    parameter int                        NUM_ENTRIES = 8,
    parameter logic [NUM_ENTRIES*32-1:0] INFO_TABLE  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CSR_AWIDTH-1:0] avs_csr_address,
    input  logic                  avs_csr_read,
    input  logic                  avs_csr_write,
    input  logic [CSR_DWIDTH-1:0] avs_csr_writedata,
    output logic [CSR_DWIDTH-1:0] avs_csr_readdata,
    output logic                  avs_csr_readdatavalid,
    output logic                  avs_csr_waitrequest
);

`ifdef EVO_XB_INFO_TABLE_AUTOINC_EN
    localparam logic AUTOINC = 1'b1;
`else
    localparam logic AUTOINC = 1'b0;
`endif

    localparam logic [31:0] LAST  = 32'(NUM_ENTRIES - 1);
    localparam logic [7:0]  LAST8 = 8'(NUM_ENTRIES - 1);

    typedef enum logic {SCAN, READY} state_t;

    state_t          state, state_nx;
    logic [7:0]      scan_idx, scan_idx_nx;
    logic [31:0]     csum, csum_nx;
    logic [31:0]     index;
    logic [CSR_AWIDTH-1:0] off;
    logic            sel, rd_acc, wr_acc, oor, ready;
    logic [1:0]      reg_sel;
    logic [31:0]     data_word, status, rd_mux;

    // Entry 0 always reports the count of additional entries.
    function automatic logic [31:0] entry(input logic [7:0] i);
        if (i == 8'd0) return LAST;
        return INFO_TABLE[32'(i)*32 +: 32];
    endfunction

    assign off     = avs_csr_address - BASE_ADDR;
    assign sel     = (avs_csr_address >= BASE_ADDR) &&
                     (off < CSR_AWIDTH'(4));
    assign reg_sel = off[1:0];
    assign ready   = (state == READY);

    assign avs_csr_waitrequest = sel && !ready;
    assign rd_acc = avs_csr_read  && sel && ready;
    assign wr_acc = avs_csr_write && sel && ready;

    assign oor       = (index >= 32'(NUM_ENTRIES));
    assign data_word = oor ? 32'h0 : entry(index[7:0]);
    assign status    = {16'h0, LAST8, 5'h0, AUTOINC, oor, ready};

    always_comb begin
        state_nx    = state;
        scan_idx_nx = scan_idx;
        csum_nx     = csum;
        unique case (state)
            SCAN: begin
                csum_nx     = csum + entry(scan_idx);
                scan_idx_nx = scan_idx + 8'd1;
                if (scan_idx == LAST8) state_nx = READY;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SCAN;
            scan_idx <= '0;
            csum     <= '0;
        end else begin
            state    <= state_nx;
            scan_idx <= scan_idx_nx;
            csum     <= csum_nx;
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (reg_sel)
            2'd0:    rd_mux = index;
            2'd1:    rd_mux = data_word;
            2'd2:    rd_mux = ready ? csum : 32'h0;
            default: rd_mux = status;
        endcase
    end

    // Auto-increment wraps at the last entry and parks when out of range.
    always_ff @(posedge clk) begin
        if (rst) begin
            index <= '0;
        end else if (wr_acc && reg_sel == 2'd0) begin
            index <= avs_csr_writedata;
        end else if (rd_acc && reg_sel == 2'd1 && AUTOINC) begin
            if (index == LAST)
                index <= '0;
            else if (!oor)
                index <= index + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            avs_csr_readdata      <= '0;
            avs_csr_readdatavalid <= 1'b0;
        end else if (rd_acc) begin
            avs_csr_readdata      <= rd_mux;
            avs_csr_readdatavalid <= 1'b1;
        end else begin
            avs_csr_readdata      <= '0;
            avs_csr_readdatavalid <= 1'b0;
        end
    end

endmodule
